pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the RV32I core. Drives the decode stage's stall and flush inputs and the fetch-stage PC redirect. It detects load-use hazards, freezes the pipeline on data-memory wait, and redirects on taken branches. It sequences trap/MRET entry through an FSM that drains in-flight instructions before redirecting to mtvec/mepc and pulsing the CSR unit.

Parameters:
XLEN, 32, datapath/PC width
DRAIN_CYCLES, 2, flush cycles after trap detect before redirect; legal 1..15
EXC_WIDTH, 4, exception vector width (ILLEGAL, ECALL, EBREAK, MRET bit indices from shared header)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
de_valid  in  1  decode holds valid instr (decode-stage clk_en input)
de_rs1  in  5  decode rs1 (combinational from decoder)
de_rs2  in  5  decode rs2
ex_valid  in  1  execute holds valid instr
ex_rd  in  5  execute destination reg
ex_load  in  1  execute instr is a load
ex_exception  in  EXC_WIDTH  registered exception flags of execute instr
ex_pc  in  XLEN  execute instr PC
ex_branch_taken  in  1  branch/jump resolved taken in execute
ex_target  in  XLEN  branch/jump target
mem_busy  in  1  data memory not ready; pipeline must freeze
csr_mtvec  in  XLEN  trap vector
csr_mepc  in  XLEN  return address
stall_out  out  1  to decode prev_stall
flush_out  out  1  to decode prev_flush (flushes fetch+decode)
redirect_valid  out  1  PC redirect strobe to fetch
redirect_pc  out  XLEN  redirect address
trap_valid  out  1  1-cycle pulse: CSR unit writes mepc/mcause
trap_cause  out  4  mcause code (2 illegal, 3 ebreak, 11 ecall-M)
trap_epc  out  XLEN  PC of trapping instr
mret_valid  out  1  1-cycle pulse: CSR unit restores status
busy  out  1  FSM not in RUN

Behaviour:
- Reset (async, rstn=0): state=RUN, drain counter=0, latched target/cause/epc=0, all registered outputs 0. Combinational outputs are 0 with idle inputs.
- exc = ex_valid && |ex_exception. load_use = de_valid && ex_valid && ex_load && ex_rd!=0 && (ex_rd==de_rs1 || ex_rd==de_rs2).
- stall_out = mem_busy || (state==RUN && !exc && !ex_branch_taken && load_use). This is combinational, same-cycle.
- RUN, priority highest first:
  1. mem_busy: stall only; exceptions/branches not accepted (execute is frozen and re-presents them).
  2. exc: latch epc=ex_pc. If MRET bit set: target=csr_mepc, kind=MRET. Otherwise target=csr_mtvec, cause from ILLEGAL>EBREAK>ECALL (2/3/11). Load counter=DRAIN_CYCLES. flush_out=1 this cycle. Go to DRAIN.
  3. ex_branch_taken: redirect_valid=1, redirect_pc=ex_target, flush_out=1, all combinational and same cycle. Stay in RUN.
  4. load_use: stall_out=1 (decode inserts bubble). Hazard clears next cycle.
- DRAIN: flush_out=1 every cycle. ex_*, de_* and branch inputs are ignored. Counter decrements when !mem_busy and holds when mem_busy (stall_out=1). Exit to REDIRECT in the cycle the counter reaches 0, i.e. DRAIN_CYCLES non-busy cycles.
- REDIRECT, one cycle, outputs driven from registers:
  - redirect_valid=1, redirect_pc=latched target, flush_out=1.
  - trap_valid=1 with trap_cause/trap_epc, or mret_valid=1 with no trap_valid.
  - Next state RUN unconditionally; mem_busy here does not delay it.
- Latency: exception seen at cycle T gives the redirect at T+DRAIN_CYCLES+1, plus any mem_busy cycles during DRAIN.
- trap_cause/trap_epc hold their last value outside the pulse.
- busy=1 in DRAIN and REDIRECT.
- Reset asserted in any state aborts the sequence immediately; no pulse is emitted.

Decomposition:
- Shared header: add FSM state encodings (RUN/DRAIN/REDIRECT) and mcause constants (2, 3, 11).
- Reuse the existing exception bit indices and EXCEPTION_WIDTH.
- One natural sub-module: hazard_detect (combinational load_use compare). Everything else stays in pipe_hazard_ctrl.

Test Plan:
1. Load-use: ex_valid=1, ex_load=1, ex_rd=5, de_valid=1, de_rs2=5 -> stall_out=1 same cycle. Then ex_rd=0 -> stall_out=0. Then ex_load=0 -> stall_out=0.
2. Branch: ex_branch_taken=1, ex_target=0x100 -> same cycle redirect_valid=1, redirect_pc=0x100, flush_out=1, busy=0. Repeat with mem_busy=1 -> no redirect, stall_out=1.
3. ECALL at T, ex_pc=0x40, csr_mtvec=0x200, DRAIN_CYCLES=2:
   - flush_out=1 at T..T+3.
   - At T+3: redirect_valid=1, redirect_pc=0x200, trap_valid=1, trap_cause=11, trap_epc=0x40.
   - At T+4: busy=0.
4. ILLEGAL plus ex_branch_taken (target 0x80) at T -> no redirect at T; trap at T+3 to mtvec with cause=2. Second case: ILLEGAL+EBREAK together -> cause=2.
5. MRET with csr_mepc=0x84 and mem_busy=1 for 3 cycles during DRAIN -> stall_out=1 during those cycles. At T+6: redirect_pc=0x84, mret_valid=1, trap_valid=0.
6. rstn deasserted at T+1 of a trap sequence -> busy=0 and all outputs 0. After release, no trap_valid pulse; a branch is handled normally.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: exception bit indices, controller FSM
// encodings and mcause codes used by the hazard/trap controller.
package pipe_hazard_ctrl_pkg;

  localparam int EXCEPTION_WIDTH = 4;
  localparam int EXC_ILLEGAL     = 0;
  localparam int EXC_ECALL       = 1;
  localparam int EXC_EBREAK      = 2;
  localparam int EXC_MRET        = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } ctrl_state_e;

  localparam logic [3:0] MCAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] MCAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] MCAUSE_ECALL_M = 4'd11;

  // Several flags may be raised together; illegal wins, then ebreak, then ecall.
  function automatic logic [3:0] exc_to_cause(input logic illegal, input logic ebreak);
    if (illegal)     return MCAUSE_ILLEGAL;
    else if (ebreak) return MCAUSE_EBREAK;
    else             return MCAUSE_ECALL_M;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline stages/CSR unit and the central hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int EXC_WIDTH = 4
);
  logic                 de_valid;
  logic [4:0]           de_rs1;
  logic [4:0]           de_rs2;
  logic                 ex_valid;
  logic [4:0]           ex_rd;
  logic                 ex_load;
  logic [EXC_WIDTH-1:0] ex_exception;
  logic [XLEN-1:0]      ex_pc;
  logic                 ex_branch_taken;
  logic [XLEN-1:0]      ex_target;
  logic                 mem_busy;
  logic [XLEN-1:0]      csr_mtvec;
  logic [XLEN-1:0]      csr_mepc;
  logic                 stall_out;
  logic                 flush_out;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 trap_valid;
  logic [3:0]           trap_cause;
  logic [XLEN-1:0]      trap_epc;
  logic                 mret_valid;
  logic                 busy;

  modport master (
    input  de_valid, de_rs1, de_rs2, ex_valid, ex_rd, ex_load, ex_exception,
           ex_pc, ex_branch_taken, ex_target, mem_busy, csr_mtvec, csr_mepc,
    output stall_out, flush_out, redirect_valid, redirect_pc, trap_valid,
           trap_cause, trap_epc, mret_valid, busy
  );

  modport slave (
    output de_valid, de_rs1, de_rs2, ex_valid, ex_rd, ex_load, ex_exception,
           ex_pc, ex_branch_taken, ex_target, mem_busy, csr_mtvec, csr_mepc,
    input  stall_out, flush_out, redirect_valid, redirect_pc, trap_valid,
           trap_cause, trap_epc, mret_valid, busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: a load in execute feeding a source register of decode.
module hazard_detect (
  input  logic       de_valid,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  output logic       load_use
);
  // x0 is never a real dependency.
  assign load_use = de_valid && ex_valid && ex_load && (ex_rd != 5'd0) &&
                    ((ex_rd == de_rs1) || (ex_rd == de_rs2));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central RV32I pipeline controller: load-use stall, memory-wait freeze, branch
// redirect, and trap/MRET sequencing (drain, then redirect and pulse the CSR unit).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int EXC_WIDTH    = EXCEPTION_WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  pipe_hazard_ctrl_if.master bus
);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  ctrl_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [3:0]      cause_q, cause_d;
  logic            mret_q, mret_d;
  logic            trap_valid_q, trap_valid_d;
  logic            mret_valid_q, mret_valid_d;
  logic [3:0]      trap_cause_q, trap_cause_d;
  logic [XLEN-1:0] trap_epc_q, trap_epc_d;

  logic            load_use, exc;
  logic            flush, redirect;
  logic [XLEN-1:0] redirect_pc;

  hazard_detect u_hazard_detect (
    .de_valid (bus.de_valid),
    .de_rs1   (bus.de_rs1),
    .de_rs2   (bus.de_rs2),
    .ex_valid (bus.ex_valid),
    .ex_load  (bus.ex_load),
    .ex_rd    (bus.ex_rd),
    .load_use (load_use)
  );

  assign exc = bus.ex_valid && (|bus.ex_exception);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    mret_d       = mret_q;
    trap_valid_d = 1'b0;
    mret_valid_d = 1'b0;
    trap_cause_d = trap_cause_q;
    trap_epc_d   = trap_epc_q;
    flush        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    unique case (state_q)
      ST_RUN: begin
        // A busy memory freezes execute, so its exception/branch is re-presented later.
        if (!bus.mem_busy) begin
          if (exc) begin
            epc_d   = bus.ex_pc;
            mret_d  = bus.ex_exception[EXC_MRET];
            cause_d = exc_to_cause(bus.ex_exception[EXC_ILLEGAL],
                                   bus.ex_exception[EXC_EBREAK]);
            target_d = bus.ex_exception[EXC_MRET] ? bus.csr_mepc : bus.csr_mtvec;
            cnt_d   = DRAIN_INIT;
            flush   = 1'b1;
            state_d = ST_DRAIN;
          end else if (bus.ex_branch_taken) begin
            redirect    = 1'b1;
            redirect_pc = bus.ex_target;
            flush       = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        if (!bus.mem_busy) begin
          cnt_d = cnt_q - 4'd1;
          // Pulse registers are loaded here so they line up with the REDIRECT cycle.
          if (cnt_q == 4'd1) begin
            state_d      = ST_REDIRECT;
            trap_valid_d = !mret_q;
            mret_valid_d = mret_q;
            if (!mret_q) begin
              trap_cause_d = cause_q;
              trap_epc_d   = epc_q;
            end
          end
        end
      end
      ST_REDIRECT: begin
        redirect    = 1'b1;
        redirect_pc = target_q;
        flush       = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      target_q     <= '0;
      epc_q        <= '0;
      cause_q      <= '0;
      mret_q       <= 1'b0;
      trap_valid_q <= 1'b0;
      mret_valid_q <= 1'b0;
      trap_cause_q <= '0;
      trap_epc_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      mret_q       <= mret_d;
      trap_valid_q <= trap_valid_d;
      mret_valid_q <= mret_valid_d;
      trap_cause_q <= trap_cause_d;
      trap_epc_q   <= trap_epc_d;
    end
  end

  assign bus.stall_out      = bus.mem_busy ||
                              ((state_q == ST_RUN) && !exc && !bus.ex_branch_taken && load_use);
  assign bus.flush_out      = flush;
  assign bus.redirect_valid = redirect;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.trap_valid     = trap_valid_q;
  assign bus.trap_cause     = trap_cause_q;
  assign bus.trap_epc       = trap_epc_q;
  assign bus.mret_valid     = mret_valid_q;
  assign bus.busy           = (state_q != ST_RUN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: combinational vector table plus
// trap/MRET/reset sequences, all checked through an expected-result queue.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int DRAIN = 2;
  localparam logic [31:0] MTVEC = 32'h0000_0200;
  localparam logic [31:0] MEPC  = 32'h0000_0084;
  localparam logic [3:0] B_ILL = 4'(1 << EXC_ILLEGAL);
  localparam logic [3:0] B_ECL = 4'(1 << EXC_ECALL);
  localparam logic [3:0] B_EBK = 4'(1 << EXC_EBREAK);
  localparam logic [3:0] B_MRT = 4'(1 << EXC_MRET);

  typedef struct {
    logic        rstn;
    logic        de_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ex_valid;
    logic [4:0]  rd;
    logic        load;
    logic [3:0]  exc;
    logic [31:0] pc;
    logic        br;
    logic [31:0] tgt;
    logic        mem_busy;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        tv;
    logic [3:0]  tc;
    logic [31:0] te;
    logic        mv;
    logic        busy;
  } out_t;

  typedef struct {
    string name;
    stim_t s;
    out_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  logic [3:0]  hold_tc = 4'd0;
  logic [31:0] hold_te = 32'd0;
  out_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[13];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.XLEN(32), .EXC_WIDTH(4)) b ();

  pipe_hazard_ctrl #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .EXC_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1; s.de_valid = 1'b0; s.rs1 = 5'd0; s.rs2 = 5'd0;
    s.ex_valid = 1'b0; s.rd = 5'd0; s.load = 1'b0; s.exc = 4'd0;
    s.pc = 32'd0; s.br = 1'b0; s.tgt = 32'd0; s.mem_busy = 1'b0;
    return s;
  endfunction

  function automatic stim_t lu(logic dv, logic [4:0] r1, logic [4:0] r2, logic ev,
                               logic [4:0] rd, logic ld, logic br, logic [31:0] tgt,
                               logic mb);
    stim_t s = idle();
    s.de_valid = dv; s.rs1 = r1; s.rs2 = r2; s.ex_valid = ev; s.rd = rd;
    s.load = ld; s.br = br; s.tgt = tgt; s.mem_busy = mb;
    return s;
  endfunction

  function automatic out_t mk(logic stall, logic flush, logic rv, logic [31:0] rpc,
                              logic tv, logic mv, logic bsy);
    out_t o;
    o.stall = stall; o.flush = flush; o.rv = rv; o.rpc = rpc; o.tv = tv;
    o.tc = hold_tc; o.te = hold_te; o.mv = mv; o.busy = bsy;
    return o;
  endfunction

  task automatic drive(stim_t s);
    rstn              = s.rstn;
    b.de_valid        = s.de_valid;
    b.de_rs1          = s.rs1;
    b.de_rs2          = s.rs2;
    b.ex_valid        = s.ex_valid;
    b.ex_rd           = s.rd;
    b.ex_load         = s.load;
    b.ex_exception    = s.exc;
    b.ex_pc           = s.pc;
    b.ex_branch_taken = s.br;
    b.ex_target       = s.tgt;
    b.mem_busy        = s.mem_busy;
    b.csr_mtvec       = MTVEC;
    b.csr_mepc        = MEPC;
  endtask

  task automatic check_one();
    out_t  e, a;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a.stall = b.stall_out; a.flush = b.flush_out; a.rv = b.redirect_valid;
    a.rpc = b.redirect_pc; a.tv = b.trap_valid; a.tc = b.trap_cause;
    a.te = b.trap_epc; a.mv = b.mret_valid; a.busy = b.busy;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got stall=%0b flush=%0b rv=%0b rpc=%h tv=%0b tc=%0d te=%h mv=%0b busy=%0b, required stall=%0b flush=%0b rv=%0b rpc=%h tv=%0b tc=%0d te=%h mv=%0b busy=%0b",
               nm, a.stall, a.flush, a.rv, a.rpc, a.tv, a.tc, a.te, a.mv, a.busy,
               e.stall, e.flush, e.rv, e.rpc, e.tv, e.tc, e.te, e.mv, e.busy);
    end
  endtask

  // Drive just after the rising edge, sample mid-cycle before the falling edge.
  task automatic step(string nm, stim_t s, out_t e);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #3;
    check_one();
  endtask

  task automatic trap_seq(string nm, logic [3:0] ex, logic [31:0] pc, logic br,
                          int nbusy, logic rd_busy, logic is_mret, logic [3:0] cause);
    stim_t s;
    logic [31:0] tgt;
    tgt = is_mret ? MEPC : MTVEC;
    s = idle(); s.ex_valid = 1'b1; s.exc = ex; s.pc = pc; s.br = br; s.tgt = 32'h80;
    step({nm, "_detect"}, s, mk(0, 1, 0, 32'd0, 0, 0, 0));
    // Branch, load-use and a fresh exception during drain must all be ignored.
    s = lu(1, 5'd5, 5'd0, 1, 5'd5, 1, 1, 32'h999, 0);
    s.exc = B_ILL;
    step({nm, "_drain0"}, s, mk(0, 1, 0, 32'd0, 0, 0, 1));
    for (int i = 0; i < nbusy; i++) begin
      s = idle(); s.mem_busy = 1'b1;
      step({nm, "_drain_busy"}, s, mk(1, 1, 0, 32'd0, 0, 0, 1));
    end
    for (int i = 1; i < DRAIN; i++)
      step({nm, "_drain"}, idle(), mk(0, 1, 0, 32'd0, 0, 0, 1));
    if (!is_mret) begin
      hold_tc = cause;
      hold_te = pc;
    end
    s = idle(); s.mem_busy = rd_busy;
    step({nm, "_redirect"}, s, mk(rd_busy, 1, 1, tgt, !is_mret, is_mret, 1));
    step({nm, "_after"}, idle(), mk(0, 0, 0, 32'd0, 0, 0, 0));
  endtask

  initial begin
    stim_t s;
    s = idle();
    s.rstn = 1'b0;
    drive(s);
    #3;
    exp_q.push_back(mk(0, 0, 0, 32'd0, 0, 0, 0));
    name_q.push_back("reset_state");
    check_one();
    step("reset_hold", s, mk(0, 0, 0, 32'd0, 0, 0, 0));

    tbl[0]  = '{"idle",        lu(0, 0, 0, 0, 0, 0, 0, 0, 0),        mk(0, 0, 0, 32'd0, 0, 0, 0)};
    tbl[1]  = '{"lu_rs2",      lu(1, 1, 5, 1, 5, 1, 0, 0, 0),        mk(1, 0, 0, 32'd0, 0, 0, 0)};
    tbl[2]  = '{"lu_rd0",      lu(1, 0, 0, 1, 0, 1, 0, 0, 0),        mk(0, 0, 0, 32'd0, 0, 0, 0)};
    tbl[3]  = '{"lu_noload",   lu(1, 1, 5, 1, 5, 0, 0, 0, 0),        mk(0, 0, 0, 32'd0, 0, 0, 0)};
    tbl[4]  = '{"lu_rs1",      lu(1, 7, 3, 1, 7, 1, 0, 0, 0),        mk(1, 0, 0, 32'd0, 0, 0, 0)};
    tbl[5]  = '{"lu_no_de",    lu(0, 7, 3, 1, 7, 1, 0, 0, 0),        mk(0, 0, 0, 32'd0, 0, 0, 0)};
    tbl[6]  = '{"lu_no_ex",    lu(1, 7, 3, 0, 7, 1, 0, 0, 0),        mk(0, 0, 0, 32'd0, 0, 0, 0)};
    tbl[7]  = '{"branch",      lu(0, 0, 0, 1, 0, 0, 1, 32'h100, 0),  mk(0, 1, 1, 32'h100, 0, 0, 0)};
    tbl[8]  = '{"branch_busy", lu(0, 0, 0, 1, 0, 0, 1, 32'h100, 1),  mk(1, 0, 0, 32'd0, 0, 0, 0)};
    tbl[9]  = '{"branch_lu",   lu(1, 1, 5, 1, 5, 1, 1, 32'h104, 0),  mk(0, 1, 1, 32'h104, 0, 0, 0)};
    tbl[10] = '{"mem_busy",    lu(0, 0, 0, 0, 0, 0, 0, 0, 1),        mk(1, 0, 0, 32'd0, 0, 0, 0)};
    tbl[11] = '{"lu_busy",     lu(1, 1, 5, 1, 5, 1, 0, 0, 1),        mk(1, 0, 0, 32'd0, 0, 0, 0)};
    tbl[12] = '{"lu_nomatch",  lu(1, 5, 7, 1, 6, 1, 0, 0, 0),        mk(0, 0, 0, 32'd0, 0, 0, 0)};
    for (int i = 0; i < 13; i++)
      step(tbl[i].name, tbl[i].s, tbl[i].e);

    trap_seq("ecall",       B_ECL,         32'h40, 1'b0, 0, 1'b0, 1'b0, 4'd11);
    trap_seq("illegal_br",  B_ILL,         32'h60, 1'b1, 0, 1'b0, 1'b0, 4'd2);
    trap_seq("ill_ebreak",  B_ILL | B_EBK, 32'h70, 1'b0, 0, 1'b0, 1'b0, 4'd2);
    trap_seq("ebreak_ecall", B_EBK | B_ECL, 32'h74, 1'b0, 1, 1'b0, 1'b0, 4'd3);
    trap_seq("mret_busy",   B_MRT,         32'h90, 1'b0, 3, 1'b1, 1'b1, 4'd0);

    // Reset in the middle of a trap sequence: no pulse, latched state cleared.
    s = idle(); s.ex_valid = 1'b1; s.exc = B_ECL; s.pc = 32'h44;
    step("abort_detect", s, mk(0, 1, 0, 32'd0, 0, 0, 0));
    hold_tc = 4'd0;
    hold_te = 32'd0;
    s = idle(); s.rstn = 1'b0;
    step("abort_in_reset", s, mk(0, 0, 0, 32'd0, 0, 0, 0));
    step("abort_in_reset2", s, mk(0, 0, 0, 32'd0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step("abort_no_pulse", idle(), mk(0, 0, 0, 32'd0, 0, 0, 0));
    step("abort_branch", lu(0, 0, 0, 1, 0, 0, 1, 32'h120, 0), mk(0, 1, 1, 32'h120, 0, 0, 0));
    step("abort_idle", idle(), mk(0, 0, 0, 32'd0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
